// File: rtl/data_cache_ctrl.sv
// data_cache_ctrl: direct-mapped, write-back, write-allocate byte cache
// sitting between the CPU memory port and a block-wide main memory.
// Hits complete with no stall; a miss stalls the CPU (BUSYWAIT) while the
// FSM writes back a dirty victim, fetches the new block, then installs it.
//
// Ports:
//   CLK, RESET                 clock, synchronous active-high reset
//   READ, WRITE                CPU byte request (level, WRITE wins if both)
//   ADDRESS, WRITEDATA         byte address {tag,index,offset}, store byte
//   READDATA, BUSYWAIT         selected byte, CPU stall (both combinational)
//   MEM_READ, MEM_WRITE        registered block read/write requests
//   MEM_ADDRESS                block address {tag,index}
//   MEM_WRITEDATA              victim block (byte 0 in bits 7:0)
//   MEM_READDATA, MEM_BUSYWAIT fetched block, memory busy
module data_cache_ctrl #(
  parameter int unsigned INDEX_BITS  = 3,
  parameter int unsigned OFFSET_BITS = 2,
  parameter int unsigned TAG_BITS    = 8 - INDEX_BITS - OFFSET_BITS
) (
  input  logic                           CLK,
  input  logic                           RESET,
  input  logic                           READ,
  input  logic                           WRITE,
  input  logic [7:0]                     ADDRESS,
  input  logic [7:0]                     WRITEDATA,
  output logic [7:0]                     READDATA,
  output logic                           BUSYWAIT,
  output logic                           MEM_READ,
  output logic                           MEM_WRITE,
  output logic [TAG_BITS+INDEX_BITS-1:0] MEM_ADDRESS,
  output logic [(8<<OFFSET_BITS)-1:0]    MEM_WRITEDATA,
  input  logic [(8<<OFFSET_BITS)-1:0]    MEM_READDATA,
  input  logic                           MEM_BUSYWAIT
);

  localparam int unsigned NUM_BLOCKS = 1 << INDEX_BITS;
  localparam int unsigned BLOCK_W    = 8 << OFFSET_BITS;
  localparam int unsigned BIT_SEL_W  = OFFSET_BITS + 3;

  typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH, UPDATE} state_t;

  state_t                 state_q, state_d;
  logic                   mem_read_q, mem_read_d;
  logic                   mem_write_q, mem_write_d;
  logic [NUM_BLOCKS-1:0]  valid_q, valid_d;
  logic [NUM_BLOCKS-1:0]  dirty_q, dirty_d;
  logic [TAG_BITS-1:0]    tag_q  [NUM_BLOCKS];
  logic [TAG_BITS-1:0]    tag_d  [NUM_BLOCKS];
  logic [BLOCK_W-1:0]     data_q [NUM_BLOCKS];
  logic [BLOCK_W-1:0]     data_d [NUM_BLOCKS];

  // Address fields and hit detection
  logic [TAG_BITS-1:0]    addr_tag;
  logic [INDEX_BITS-1:0]  addr_idx;
  logic [OFFSET_BITS-1:0] addr_off;
  logic [BIT_SEL_W-1:0]   bit_base;
  logic                   req_c;
  logic                   hit_c;

  assign addr_tag = ADDRESS[7 -: TAG_BITS];
  assign addr_idx = ADDRESS[OFFSET_BITS +: INDEX_BITS];
  assign addr_off = ADDRESS[OFFSET_BITS-1:0];
  assign bit_base = {addr_off, 3'b000};
  assign req_c    = READ || WRITE;
  assign hit_c    = valid_q[addr_idx] && (tag_q[addr_idx] == addr_tag);

  // Next-state, hit write and block install
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    dirty_d = dirty_q;
    tag_d   = tag_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (req_c) begin
          if (hit_c) begin
            if (WRITE) begin
              data_d[addr_idx][bit_base +: 8] = WRITEDATA;
              dirty_d[addr_idx]               = 1'b1;
            end
          end else if (valid_q[addr_idx] && dirty_q[addr_idx]) begin
            state_d = WRITEBACK;
          end else begin
            state_d = FETCH;
          end
        end
      end
      WRITEBACK: if (!MEM_BUSYWAIT) state_d = FETCH;
      FETCH:     if (!MEM_BUSYWAIT) state_d = UPDATE;
      UPDATE: begin
        data_d[addr_idx]  = MEM_READDATA;
        tag_d[addr_idx]   = addr_tag;
        valid_d[addr_idx] = 1'b1;
        dirty_d[addr_idx] = 1'b0;
        state_d           = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Memory strobes are decodes of the state being entered
    mem_read_d  = (state_d == FETCH);
    mem_write_d = (state_d == WRITEBACK);
  end

  // Control state with synchronous reset
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= IDLE;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      valid_q     <= '0;
      dirty_q     <= '0;
    end else begin
      state_q     <= state_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      valid_q     <= valid_d;
      dirty_q     <= dirty_d;
    end
  end

  // Tag and data arrays are qualified by valid, so they need no reset
  always_ff @(posedge CLK) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

  assign MEM_READ      = mem_read_q;
  assign MEM_WRITE     = mem_write_q;
  assign MEM_ADDRESS   = (state_q == WRITEBACK) ? {tag_q[addr_idx], addr_idx}
                                                : {addr_tag, addr_idx};
  assign MEM_WRITEDATA = data_q[addr_idx];
  assign READDATA      = data_q[addr_idx][bit_base +: 8];
  assign BUSYWAIT      = (state_q != IDLE) || (req_c && !hit_c);

endmodule

// File: tb/tb_data_cache_ctrl.sv
// Bench for data_cache_ctrl: directed hit vectors from a table plus
// hand-written miss, dirty eviction, read+write and reset-mid-fetch sequences
// against a read-only block memory with a 5-cycle access time.
module tb_data_cache_ctrl;

  localparam int unsigned M = 5;

  logic        CLK = 1'b0;
  logic        RESET, READ, WRITE;
  logic [7:0]  ADDRESS, WRITEDATA, READDATA;
  logic        BUSYWAIT, MEM_READ, MEM_WRITE, MEM_BUSYWAIT;
  logic [5:0]  MEM_ADDRESS;
  logic [31:0] MEM_WRITEDATA, MEM_READDATA;

  int n_checks = 0;
  int n_fail   = 0;

  data_cache_ctrl dut (
    .CLK(CLK), .RESET(RESET), .READ(READ), .WRITE(WRITE),
    .ADDRESS(ADDRESS), .WRITEDATA(WRITEDATA), .READDATA(READDATA),
    .BUSYWAIT(BUSYWAIT), .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
    .MEM_ADDRESS(MEM_ADDRESS), .MEM_WRITEDATA(MEM_WRITEDATA),
    .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT)
  );

  always #5 CLK = ~CLK;

  // Block memory: each access is busy until its M-th cycle
  logic [31:0] mem [64];
  int unsigned mcnt = 0;

  assign MEM_BUSYWAIT = (MEM_READ || MEM_WRITE) && (mcnt != M - 1);
  assign MEM_READDATA = mem[MEM_ADDRESS];

  always @(posedge CLK) begin
    if (RESET)                                mcnt <= 0;
    else if ((MEM_READ || MEM_WRITE) && mcnt != M - 1) mcnt <= mcnt + 1;
    else                                      mcnt <= 0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Miss bookkeeping filled in by do_miss
  logic       saw_wb, saw_rd, order_err, both_err;
  logic [5:0] wb_addr, rd_addr;
  logic [31:0] wb_data;

  // Called just after a negedge: issue request, count stall cycles until the
  // hit cycle (sampled 1 time unit after a negedge), bounded at 100 cycles.
  task automatic do_miss(input logic rd, input logic wr, input logic [7:0] a,
                         input logic [7:0] d, output int cycles);
    READ = rd; WRITE = wr; ADDRESS = a; WRITEDATA = d;
    cycles = 0;
    saw_wb = 0; saw_rd = 0; order_err = 0; both_err = 0;
    wb_addr = '0; rd_addr = '0; wb_data = '0;
    #1;
    while (BUSYWAIT && cycles < 100) begin
      cycles++;
      if (MEM_READ && MEM_WRITE) both_err = 1;
      if (MEM_WRITE) begin
        if (saw_rd) order_err = 1;
        if (!saw_wb) begin
          saw_wb = 1; wb_addr = MEM_ADDRESS; wb_data = MEM_WRITEDATA;
        end
      end
      if (MEM_READ && !saw_rd) begin
        saw_rd = 1; rd_addr = MEM_ADDRESS;
      end
      @(negedge CLK); #1;
    end
  endtask

  typedef struct {
    string      name;
    logic       rd;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       chk_rd;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t vecs [6];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    for (int i = 0; i < 64; i++) mem[i] = {4{8'(i)}} ^ 32'h0F0F_0F0F;
    mem[1]  = 32'hDDCC_BBAA;
    mem[9]  = 32'h4433_2211;
    mem[2]  = 32'h8765_4321;
    mem[10] = 32'hA1B2_C3D4;

    vecs[0] = '{"hit_rd_07", 1'b1, 1'b0, 8'h07, 8'h00, 1'b1, 8'hDD};
    vecs[1] = '{"hit_rd_04", 1'b1, 1'b0, 8'h04, 8'h00, 1'b1, 8'hAA};
    vecs[2] = '{"idle_07",   1'b0, 1'b0, 8'h07, 8'h00, 1'b1, 8'hDD};
    vecs[3] = '{"hit_wr_06", 1'b0, 1'b1, 8'h06, 8'h5A, 1'b0, 8'h00};
    vecs[4] = '{"hit_rd_06", 1'b1, 1'b0, 8'h06, 8'h00, 1'b1, 8'h5A};
    vecs[5] = '{"hit_rd_05", 1'b1, 1'b0, 8'h05, 8'h00, 1'b1, 8'hBB};

    RESET = 1; READ = 0; WRITE = 0; ADDRESS = 0; WRITEDATA = 0;
    repeat (2) @(negedge CLK);
    #1;
    chk("rst_busywait",  32'(BUSYWAIT),  32'd0);
    chk("rst_mem_read",  32'(MEM_READ),  32'd0);
    chk("rst_mem_write", 32'(MEM_WRITE), 32'd0);
    @(negedge CLK);
    RESET = 0;

    // Clean miss on read 0x05
    do_miss(1'b1, 1'b0, 8'h05, 8'h00, cyc);
    chk("clean_miss_cycles", 32'(cyc),         32'd7);
    chk("clean_miss_rd_seen", 32'(saw_rd),     32'd1);
    chk("clean_miss_rd_addr", 32'(rd_addr),    32'h01);
    chk("clean_miss_no_wb",  32'(saw_wb),      32'd0);
    chk("clean_miss_data",   32'(READDATA),    32'hBB);

    // Zero-stall hit vectors
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      READ = vecs[i].rd; WRITE = vecs[i].wr;
      ADDRESS = vecs[i].addr; WRITEDATA = vecs[i].wdata;
      #1;
      chk({vecs[i].name, "_busy"}, 32'(BUSYWAIT), 32'd0);
      if (vecs[i].chk_rd) chk({vecs[i].name, "_data"}, 32'(READDATA), 32'(vecs[i].exp_rd));
    end

    // Dirty eviction of index 1 by read 0x25
    @(negedge CLK);
    do_miss(1'b1, 1'b0, 8'h25, 8'h00, cyc);
    chk("dirty_miss_cycles", 32'(cyc),       32'd12);
    chk("dirty_wb_seen",     32'(saw_wb),    32'd1);
    chk("dirty_wb_addr",     32'(wb_addr),   32'h01);
    chk("dirty_wb_data",     wb_data,        32'hDD5A_BBAA);
    chk("dirty_rd_addr",     32'(rd_addr),   32'h09);
    chk("dirty_order",       32'(order_err), 32'd0);
    chk("dirty_both_high",   32'(both_err),  32'd0);
    chk("dirty_miss_data",   32'(READDATA),  32'h22);

    // READ and WRITE together on a clean miss: write-allocate
    @(negedge CLK);
    do_miss(1'b1, 1'b1, 8'h0A, 8'hC3, cyc);
    chk("rw_miss_cycles", 32'(cyc),     32'd7);
    chk("rw_miss_no_wb",  32'(saw_wb),  32'd0);
    chk("rw_miss_rd_addr", 32'(rd_addr), 32'h02);
    @(negedge CLK);
    READ = 1; WRITE = 0; ADDRESS = 8'h0A;
    #1;
    chk("rw_readback_busy", 32'(BUSYWAIT), 32'd0);
    chk("rw_readback_data", 32'(READDATA), 32'hC3);
    ADDRESS = 8'h08;
    #1;
    chk("rw_other_byte", 32'(READDATA), 32'h21);

    // Evicting index 2 proves the allocated write left it dirty
    @(negedge CLK);
    do_miss(1'b1, 1'b0, 8'h2A, 8'h00, cyc);
    chk("rw_evict_cycles",  32'(cyc),     32'd12);
    chk("rw_evict_wb_addr", 32'(wb_addr), 32'h02);
    chk("rw_evict_wb_data", wb_data,      32'h87C3_4321);
    chk("rw_evict_rd_addr", 32'(rd_addr), 32'h0A);
    chk("rw_evict_data",    32'(READDATA), 32'hB2);

    // Reset while in FETCH
    @(negedge CLK);
    READ = 1; WRITE = 0; ADDRESS = 8'h05;
    #1;
    chk("rst_fetch_miss_busy", 32'(BUSYWAIT), 32'd1);
    repeat (3) @(negedge CLK);
    #1;
    chk("rst_fetch_in_fetch", 32'(MEM_READ), 32'd1);
    RESET = 1; READ = 0;
    @(negedge CLK);
    RESET = 0;
    #1;
    chk("rst_fetch_mem_read",  32'(MEM_READ),  32'd0);
    chk("rst_fetch_mem_write", 32'(MEM_WRITE), 32'd0);
    chk("rst_fetch_busywait",  32'(BUSYWAIT),  32'd0);
    READ = 1; ADDRESS = 8'h25;
    #1;
    chk("rst_invalid_idx1", 32'(BUSYWAIT), 32'd1);
    ADDRESS = 8'h2A;
    #1;
    chk("rst_invalid_idx2", 32'(BUSYWAIT), 32'd1);
    do_miss(1'b1, 1'b0, 8'h05, 8'h00, cyc);
    chk("rst_remiss_cycles", 32'(cyc),      32'd7);
    chk("rst_remiss_no_wb",  32'(saw_wb),   32'd0);
    chk("rst_remiss_data",   32'(READDATA), 32'hBB);

    @(negedge CLK);
    READ = 0; WRITE = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_cache_ctrl.md
Name: data_cache_ctrl

Overview:
- Direct-mapped, write-back, write-allocate data cache between the CPU datapath's memory port (READ, WRITE, BUSYWAIT from the control unit) and the block-wide main data memory.
- Serves byte reads and writes on hits without stalling.
- On a miss, holds BUSYWAIT high while an FSM writes back a dirty victim block and fetches the new block.

Parameters:
- INDEX_BITS, 3, log2 of cache block count (8 blocks).
- OFFSET_BITS, 2, log2 of bytes per block (4 bytes = 32-bit block).
- TAG_BITS, 3, equals 8 - INDEX_BITS - OFFSET_BITS.

Ports:
- CLK  in  1  system clock; all state updates on posedge.
- RESET  in  1  synchronous, active-high reset.
- READ  in  1  CPU byte-read request, level; held until BUSYWAIT low.
- WRITE  in  1  CPU byte-write request, level; held until BUSYWAIT low.
- ADDRESS  in  8  byte address {tag, index, offset}.
- WRITEDATA  in  8  byte to store.
- READDATA  out  8  selected byte of the indexed block.
- BUSYWAIT  out  1  stall to CPU.
- MEM_READ  out  1  main-memory block read request.
- MEM_WRITE  out  1  main-memory block write request.
- MEM_ADDRESS  out  6  block address {tag, index}.
- MEM_WRITEDATA  out  32  victim block, byte 0 in bits 7:0.
- MEM_READDATA  in  32  fetched block, byte 0 in bits 7:0.
- MEM_BUSYWAIT  in  1  high while memory is busy with a request.

Behaviour:
- Storage:
  - per block: valid bit, dirty bit, TAG_BITS tag, 32-bit data.
  - Byte at offset k is data[8k+7:8k].
- Reset (sync, RESET high at posedge):
  - all valid=0, dirty=0, state=IDLE.
  - MEM_READ=0, MEM_WRITE=0, BUSYWAIT=0.
  - Data/tag arrays need not clear.
  - RESET mid-miss abandons the memory transaction; MEM_READ/MEM_WRITE are low after that edge.
- hit = valid[index] && tag[index]==ADDRESS tag. Combinational.
- Request = READ || WRITE.
  - READ and WRITE both high is illegal; WRITE takes priority.
- IDLE, request and hit:
  - BUSYWAIT=0 combinationally in the same cycle.
  - Read: READDATA is the selected byte, combinational.
  - Write: byte written and dirty[index]=1 at the next posedge.
  - Zero-stall hit.
- IDLE, request and miss:
  - BUSYWAIT=1 combinationally.
  - Next state is WRITEBACK if valid && dirty, else FETCH.
- IDLE, no request: BUSYWAIT=0, READDATA holds the indexed byte.
- WRITEBACK:
  - MEM_WRITE=1, MEM_ADDRESS={stored tag, index}, MEM_WRITEDATA=stored block.
  - Remain while MEM_BUSYWAIT=1.
  - On the first posedge with MEM_BUSYWAIT=0 after at least one cycle in the state, go to FETCH.
- FETCH:
  - MEM_READ=1, MEM_ADDRESS={ADDRESS tag, index}.
  - Same exit rule as WRITEBACK; go to UPDATE.
- UPDATE, exactly one cycle:
  - At the posedge: data[index]=MEM_READDATA, tag updated, valid=1, dirty=0.
  - BUSYWAIT stays 1.
  - Next state IDLE, where the request re-evaluates as a hit and completes.
- MEM_READ and MEM_WRITE are registered state decodes, never high together, and 0 in IDLE/UPDATE.
- BUSYWAIT is 1 in every non-IDLE state.
- Address/data inputs must stay stable while BUSYWAIT=1.
  - A request dropped mid-miss still completes the fill, then idles.
- Miss latency, with memory stall M cycles per access:
  - clean miss: 1 (IDLE detect) + M + 1 (UPDATE) cycles of BUSYWAIT before the hit cycle.
  - dirty miss: adds M.

Test Plan:
- Reset, then READ ADDRESS=0x05; memory (M=5) returns 0xDDCCBBAA.
  -> MEM_READ=1 with MEM_ADDRESS=0x01, no MEM_WRITE.
  -> BUSYWAIT high 7 cycles, then READDATA=0xBB with BUSYWAIT=0.
- Next, READ 0x07.
  -> hit: BUSYWAIT never rises, READDATA=0xDD in the same cycle.
- WRITE 0x06 data 0x5A (hit).
  -> no stall; subsequent READ 0x06 returns 0x5A; dirty[1]=1.
- READ 0x25 (same index 1, tag 1).
  -> MEM_WRITE first: MEM_ADDRESS=0x01, MEM_WRITEDATA=0xDD5ABBAA.
  -> then MEM_READ with MEM_ADDRESS=0x09; byte from the new block returned.
- READ and WRITE both high on a miss to a clean block.
  -> treated as write-allocate; byte written after fill, dirty=1.
- RESET asserted during FETCH.
  -> after the edge: MEM_READ=0, BUSYWAIT=0, valid all 0.
  -> READ 0x05 misses again.
